// File: rtl/dm_cache_pkg.sv
// Shared types and default widths for the direct-mapped cache controller.
package dm_cache_pkg;

  localparam int unsigned ADDR_W_DEF  = 12;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned INDEX_W_DEF = 4;
  localparam int unsigned CNT_W_DEF   = 16;

  // Controller sequencing states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/dm_cache_tag_store.sv
// Tag and valid arrays: combinational lookup, single-entry write, one-cycle clear-all.
module dm_cache_tag_store #(
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned TAG_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] lkp_idx_i,
  input  logic [TAG_W-1:0]   lkp_tag_i,
  output logic               lkp_hit_c_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic               clr_all_i
);

  localparam int unsigned LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LINES];

  // Clear-all wins over a line fill; the controller never issues both together
  always_comb begin
    valid_d = valid_q;
    if (clr_all_i) begin
      valid_d = '0;
    end else if (wr_en_i) begin
      valid_d[wr_idx_i] = 1'b1;
    end
  end

  // Valid bit register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag array, written on line fill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(LINES); i++) begin
        tag_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
    end
  end

  assign lkp_hit_c_o = valid_q[lkp_idx_i] && (tag_q[lkp_idx_i] == lkp_tag_i);

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped cache sequencer: hit/miss resolution, read-miss refill, write-through.
module dm_cache_ctrl
  import dm_cache_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned INDEX_W = INDEX_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               resp_valid,
  output logic [DATA_W-1:0]  resp_rdata,
  input  logic               inv_all,
  output logic [INDEX_W-1:0] cache_addr,
  output logic               cache_we,
  output logic [DATA_W-1:0]  cache_wdata,
  input  logic [DATA_W-1:0]  cache_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_ack,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

  logic                hit_c;
  logic                tag_wr_c;
  logic                clr_all_c;
  logic [INDEX_W-1:0]  idx_q_c;
  logic [TAG_W-1:0]    tag_lat_c;

  assign idx_q_c   = addr_q[INDEX_W-1:0];
  assign tag_lat_c = addr_q[ADDR_W-1:INDEX_W];

  dm_cache_tag_store #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_tag_store (
    .clk         (clk),
    .rst         (rst),
    .lkp_idx_i   (idx_q_c),
    .lkp_tag_i   (tag_lat_c),
    .lkp_hit_c_o (hit_c),
    .wr_en_i     (tag_wr_c),
    .wr_idx_i    (idx_q_c),
    .wr_tag_i    (tag_lat_c),
    .clr_all_i   (clr_all_c)
  );

  // Next-state, request latching, counters and array/tag write strobes
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    cache_we     = 1'b0;
    tag_wr_c     = 1'b0;
    clr_all_c    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (inv_all) begin
          clr_all_c = 1'b1;
        end else if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit_c) begin
          hit_cnt_d = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + CNT_W'(1);
        end else begin
          miss_cnt_d = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + CNT_W'(1);
        end
        if (we_q) begin
          // Write-through; only an already-resident line is updated
          cache_we = hit_c;
          state_d  = ST_MEM_WR;
        end else if (hit_c) begin
          resp_rdata_d = cache_rdata;
          state_d      = ST_RESP;
        end else begin
          state_d = ST_MEM_RD;
        end
      end
      ST_MEM_RD: begin
        if (mem_ack) begin
          cache_we     = 1'b1;
          tag_wr_c     = 1'b1;
          resp_rdata_d = mem_rdata;
          state_d      = ST_RESP;
        end
      end
      ST_MEM_WR: begin
        if (mem_ack) begin
          resp_rdata_d = '0;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, request latches, response data and statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      resp_rdata_q <= resp_rdata_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Interface decode; memory fields come from latches so they hold until ack
  assign req_ready   = (state_q == ST_IDLE) && !inv_all;
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_rdata  = resp_rdata_q;
  assign mem_req     = (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
  assign mem_we      = (state_q == ST_MEM_WR);
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign cache_addr  = ((state_q == ST_LOOKUP) || (state_q == ST_MEM_RD)) ?
                       idx_q_c : req_addr[INDEX_W-1:0];
  assign cache_wdata = (state_q == ST_MEM_RD) ? mem_rdata : wdata_q;
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: directed scenarios then random traffic against a line-level model.
module tb_dm_cache_ctrl;

  localparam int unsigned AW   = 12;
  localparam int unsigned DW   = 32;
  localparam int unsigned IW   = 4;
  localparam int unsigned CW   = 6;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          inv_all;
  logic [IW-1:0] cache_addr;
  logic          cache_we;
  logic [DW-1:0] cache_wdata, cache_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] hit_cnt, miss_cnt;

  dm_cache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .INDEX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .inv_all(inv_all),
    .cache_addr(cache_addr), .cache_we(cache_we), .cache_wdata(cache_wdata),
    .cache_rdata(cache_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Cache data array: combinational read, synchronous write
  logic [DW-1:0] carr [1 << IW];
  assign cache_rdata = carr[cache_addr];
  always @(posedge clk) begin
    if (cache_we) carr[cache_addr] <= cache_wdata;
  end

  // Main memory with a programmable ack delay
  logic [DW-1:0] mem_arr [1 << AW];
  int unsigned   ack_delay;
  int unsigned   n_mem_rd, n_mem_wr;
  logic [AW-1:0] last_rd_addr, last_wr_addr;
  logic [DW-1:0] last_wr_data;

  initial begin
    int unsigned wcnt;
    for (int i = 0; i < (1 << AW); i++) mem_arr[i] = $urandom;
    mem_arr[1] = 32'h1234_5678;
    mem_ack = 1'b0; mem_rdata = '0;
    n_mem_rd = 0; n_mem_wr = 0;
    last_rd_addr = '0; last_wr_addr = '0; last_wr_data = '0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req && !rst) begin
        if (wcnt == 0) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem_arr[mem_addr] = mem_wdata;
            last_wr_addr = mem_addr; last_wr_data = mem_wdata;
            n_mem_wr++;
          end else begin
            mem_rdata = mem_arr[mem_addr];
            last_rd_addr = mem_addr;
            n_mem_rd++;
          end
          wcnt = ack_delay;
        end else begin
          wcnt--;
        end
      end else begin
        wcnt = ack_delay;
      end
    end
  end

  // Reference model: which full address each line holds, plus statistics
  logic          m_valid [1 << IW];
  logic [AW-1:0] m_addr  [1 << IW];
  int unsigned   m_hits, m_miss;
  int unsigned   n_cmp, n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < (1 << IW); i++) m_valid[i] = 1'b0;
  endtask

  // One request end-to-end; d is the memory ack delay
  task automatic do_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input int unsigned d);
    logic [IW-1:0] ix;
    logic          hit;
    logic [DW-1:0] exp_rd;
    int unsigned   rd0, wr0, lat, guard, exp_lat;
    ix     = a[IW-1:0];
    hit    = m_valid[ix] && (m_addr[ix] == a);
    exp_rd = we ? '0 : mem_arr[a];
    rd0 = n_mem_rd; wr0 = n_mem_wr;
    ack_delay = d;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    check("req_ready", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 60) begin @(negedge clk); lat++; end
    exp_lat = (we || !hit) ? 3 + d : 2;
    check("resp_seen", 64'(resp_valid), 64'(1));
    check("latency", 64'(lat), 64'(exp_lat));
    check("resp_rdata", 64'(resp_rdata), 64'(exp_rd));
    if (hit) m_hits = (m_hits == CMAX) ? CMAX : m_hits + 1;
    else     m_miss = (m_miss == CMAX) ? CMAX : m_miss + 1;
    if (!we && !hit) begin m_valid[ix] = 1'b1; m_addr[ix] = a; end
    check("hit_cnt", 64'(hit_cnt), 64'(m_hits));
    check("miss_cnt", 64'(miss_cnt), 64'(m_miss));
    check("mem_rd_count", 64'(n_mem_rd - rd0), 64'((!we && !hit) ? 1 : 0));
    check("mem_wr_count", 64'(n_mem_wr - wr0), 64'(we ? 1 : 0));
    if (we) begin
      check("mem_wr_addr", 64'(last_wr_addr), 64'(a));
      check("mem_wr_data", 64'(last_wr_data), 64'(wd));
    end else if (!hit) begin
      check("mem_rd_addr", 64'(last_rd_addr), 64'(a));
    end
    @(negedge clk);
    check("resp_pulse", 64'(resp_valid), 64'(0));
  endtask

  // Invalidate-all pulse in IDLE, optionally with a competing request
  task automatic do_inv(input logic rv, input logic [AW-1:0] a);
    @(negedge clk);
    inv_all = 1'b1; req_valid = rv; req_we = 1'b0; req_addr = a;
    #1;
    check("inv_ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    inv_all = 1'b0; req_valid = 1'b0;
    model_clear();
    @(negedge clk);
    check("inv_no_accept", 64'(mem_req | resp_valid), 64'(0));
  endtask

  initial begin
    int unsigned seen, guard;
    n_cmp = 0; n_err = 0; m_hits = 0; m_miss = 0;
    model_clear();
    for (int i = 0; i < (1 << IW); i++) m_addr[i] = '0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    inv_all = 1'b0; ack_delay = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_hit_cnt", 64'(hit_cnt), 64'(0));
    check("rst_miss_cnt", 64'(miss_cnt), 64'(0));
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(req_ready), 64'(1));

    // Cold miss, re-read hit, write hit then read, conflicting tag
    do_op(1'b0, 12'h001, '0, 3);
    do_op(1'b0, 12'h001, '0, 3);
    do_op(1'b1, 12'h001, 32'hFFFF_FFFF, 2);
    do_op(1'b0, 12'h001, '0, 1);
    do_op(1'b0, 12'h011, '0, 2);
    do_op(1'b0, 12'h001, '0, 1);

    // Invalidate with a simultaneous request, then the line misses
    do_inv(1'b1, 12'h011);
    do_op(1'b0, 12'h011, '0, 1);

    // Reset during a refill: request drops immediately, no response
    ack_delay = 20;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h022;
    @(posedge clk); #1;
    req_valid = 1'b0;
    guard = 0;
    while (!mem_req && guard < 10) begin @(negedge clk); guard++; end
    check("rst_pre_mem_req", 64'(mem_req), 64'(1));
    #1 rst = 1'b1;
    #1 check("rst_mem_req_drop", 64'(mem_req), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear(); m_hits = 0; m_miss = 0;
    seen = 0;
    repeat (10) begin @(negedge clk); if (resp_valid) seen++; end
    check("rst_no_resp", 64'(seen), 64'(0));
    check("rst2_hit_cnt", 64'(hit_cnt), 64'(0));

    // Ack in the first request cycle, then drive the hit counter to saturation
    do_op(1'b0, 12'h0A5, '0, 0);
    for (int i = 0; i < int'(CMAX) + 3; i++) do_op(1'b0, 12'h0A5, '0, 0);
    check("hit_sat", 64'(hit_cnt), 64'(CMAX));

    // Random traffic over a small address set to mix hits, misses and conflicts
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] a;
      a = {AW'($urandom_range(0, 3)) << IW} | AW'($urandom_range(0, (1 << IW) - 1));
      if ($urandom_range(0, 99) < 5) do_inv(1'($urandom_range(0, 1)), a);
      else do_op(1'($urandom_range(0, 99) < 30), a, $urandom, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
